// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the AES round sequencer
// (slave side) and the requester / datapath that drives it (master side).
interface aes_round_ctrl_if;
  logic       start;
  logic       ready;
  logic [1:0] mux_sel;
  logic       state_en;
  logic       key_en;
  logic [3:0] round_idx;
  logic       busy;
  logic       out_valid;
  logic       out_ready;

  // Sequencer side: consumes requests and the consumer accept, drives controls
  modport slave (
    input  start,
    input  out_ready,
    output ready,
    output mux_sel,
    output state_en,
    output key_en,
    output round_idx,
    output busy,
    output out_valid
  );

  // Requester / consumer side
  modport master (
    output start,
    output out_ready,
    input  ready,
    input  mux_sel,
    input  state_en,
    input  key_en,
    input  round_idx,
    input  busy,
    input  out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: steps the state register through the initial
// AddRoundKey, NUM_ROUNDS-1 full rounds and the final round, each round lasting
// ROUND_CYCLES clocks, then holds the ciphertext valid until it is accepted.
// Every output is a register loaded from the decode of the next state, so the
// datapath sees glitch-free controls aligned with the state it is in.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS   = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  aes_round_ctrl_if.slave bus
);

  // Sub-cycle counter is at least one bit wide even for single-cycle rounds
  localparam int CW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CW-1:0] SUB_LAST   = CW'(ROUND_CYCLES - 1);
  localparam logic [CW-1:0] SUB_ONE    = CW'(1);
  localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0]    ROUND_ONE  = 4'd1;

  // Reject illegal configurations at elaboration
  if (NUM_ROUNDS < 2 || NUM_ROUNDS > 15) begin : g_bad_num_rounds
    $error("aes_round_ctrl: NUM_ROUNDS must be in 2..15");
  end
  if (ROUND_CYCLES < 1) begin : g_bad_round_cycles
    $error("aes_round_ctrl: ROUND_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_OUT
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] sub_reg, sub_next;
  logic [3:0]    round_reg, round_next;

  logic       ready_reg, ready_next;
  logic       busy_reg, busy_next;
  logic       out_valid_reg, out_valid_next;
  logic [1:0] mux_sel_reg, mux_sel_next;
  logic       state_en_reg, state_en_next;

  // State, counters and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      sub_reg       <= '0;
      round_reg     <= 4'd0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      mux_sel_reg   <= 2'b11;
      state_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sub_reg       <= sub_next;
      round_reg     <= round_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      out_valid_reg <= out_valid_next;
      mux_sel_reg   <= mux_sel_next;
      state_en_reg  <= state_en_next;
    end
  end

  // Next-state sequencing and decode of the controls for the next state
  always_comb begin
    state_next = state_reg;
    sub_next   = sub_reg;
    round_next = round_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_INIT;
          sub_next   = '0;
          round_next = 4'd0;
        end
      end
      S_INIT: begin
        state_next = S_ROUND;
        sub_next   = '0;
        round_next = ROUND_ONE;
      end
      S_ROUND: begin
        if (sub_reg == SUB_LAST) begin
          sub_next   = '0;
          round_next = round_reg + ROUND_ONE;
          if (round_reg == LAST_ROUND) begin
            state_next = S_FINAL;
          end
        end else begin
          sub_next = sub_reg + SUB_ONE;
        end
      end
      S_FINAL: begin
        if (sub_reg == SUB_LAST) begin
          state_next = S_OUT;
          sub_next   = '0;
        end else begin
          sub_next = sub_reg + SUB_ONE;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
          round_next = 4'd0;
        end
      end
      default: begin
        state_next = S_IDLE;
        sub_next   = '0;
        round_next = 4'd0;
      end
    endcase

    ready_next     = (state_next == S_IDLE);
    busy_next      = (state_next == S_INIT) || (state_next == S_ROUND) ||
                     (state_next == S_FINAL);
    out_valid_next = (state_next == S_OUT);

    case (state_next)
      S_INIT:  mux_sel_next = 2'b00;
      S_ROUND: mux_sel_next = 2'b01;
      S_FINAL: mux_sel_next = 2'b10;
      default: mux_sel_next = 2'b11;
    endcase

    // Load the state register on INIT and on the closing cycle of every round
    state_en_next = (state_next == S_INIT) ||
                    (((state_next == S_ROUND) || (state_next == S_FINAL)) &&
                     (sub_next == SUB_LAST));
  end

  assign bus.ready     = ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.mux_sel   = mux_sel_reg;
  assign bus.state_en  = state_en_reg;
  assign bus.key_en    = state_en_reg;
  assign bus.round_idx = round_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: two instances (single-cycle and 3-cycle rounds)
// checked cycle by cycle against a model that derives the expected controls
// from the cycle offset after the accept edge.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       out_valid;
    logic [1:0] mux_sel;
    logic       state_en;
    logic       key_en;
    logic [3:0] round_idx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  aes_round_ctrl_if bus_a ();
  aes_round_ctrl_if bus_b ();

  aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_CYCLES(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_CYCLES(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Expected outputs k cycles after the accept edge (k<=0 means idle)
  function automatic obs_t model(input int k, input int nr, input int rc);
    obs_t o;
    int   j;
    o = '{ready: 1'b1, busy: 1'b0, out_valid: 1'b0, mux_sel: 2'b11,
          state_en: 1'b0, key_en: 1'b0, round_idx: 4'd0};
    if (k <= 0) return o;
    o.ready = 1'b0;
    if (k == 1) begin
      o.busy = 1'b1; o.mux_sel = 2'b00; o.state_en = 1'b1; o.round_idx = 4'd0;
    end else if (k <= 1 + (nr - 1) * rc) begin
      j = k - 2;
      o.busy = 1'b1; o.mux_sel = 2'b01;
      o.round_idx = 4'(j / rc + 1);
      o.state_en = ((j % rc) == rc - 1);
    end else if (k <= 1 + nr * rc) begin
      j = k - 2 - (nr - 1) * rc;
      o.busy = 1'b1; o.mux_sel = 2'b10;
      o.round_idx = 4'(nr);
      o.state_en = (j == rc - 1);
    end else begin
      o.out_valid = 1'b1; o.round_idx = 4'(nr);
    end
    o.key_en = o.state_en;
    return o;
  endfunction

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0)
      o = '{bus_a.ready, bus_a.busy, bus_a.out_valid, bus_a.mux_sel,
            bus_a.state_en, bus_a.key_en, bus_a.round_idx};
    else
      o = '{bus_b.ready, bus_b.busy, bus_b.out_valid, bus_b.mux_sel,
            bus_b.state_en, bus_b.key_en, bus_b.round_idx};
    return o;
  endfunction

  task automatic drive(input int sel, input bit s, input bit o);
    if (sel == 0) begin
      bus_a.start = s; bus_a.out_ready = o;
    end else begin
      bus_b.start = s; bus_b.out_ready = o;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (rdy,bsy,vld,mux,sen,ken,rnd)",
             tag, got, exp);
    end
  endtask

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  // One full request: accept, sequence, optional backpressure, accept output.
  // abort_at>0 pulses reset in that cycle and checks the idle result instead.
  task automatic run_seq(input int sel, input int start_hold, input int bp,
                         input bit start_in_bp, input int abort_at,
                         input bit noise, input string name);
    int rc;
    int last_k;
    rc     = (sel == 0) ? 1 : 3;
    last_k = NR * rc + 2;
    drive(sel, 1'b1, noise ? rbit() : 1'b0);
    for (int k = 1; k <= last_k; k++) begin
      tick();
      check($sformatf("%s k=%0d", name, k), get_obs(sel), model(k, NR, rc));
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        check($sformatf("%s reset_at=%0d", name, k), get_obs(sel), model(0, NR, rc));
        rst = 1'b0;
        drive(sel, 1'b0, 1'b0);
        return;
      end
      if (k < last_k)
        drive(sel, (k < start_hold) ? 1'b1 : (noise ? rbit() : 1'b0),
              noise ? rbit() : 1'b0);
    end
    for (int b = 0; b < bp; b++) begin
      drive(sel, start_in_bp, 1'b0);
      tick();
      check($sformatf("%s hold b=%0d", name, b), get_obs(sel), model(last_k, NR, rc));
    end
    drive(sel, 1'b0, 1'b1);
    tick();
    check($sformatf("%s accepted", name), get_obs(sel), model(0, NR, rc));
    drive(sel, 1'b0, noise ? rbit() : 1'b0);
    tick();
    check($sformatf("%s idle", name), get_obs(sel), model(0, NR, rc));
  endtask

  initial begin
    int sel;
    int rc;
    // Reset with random inputs on both instances
    rst = 1'b1;
    drive(0, rbit(), rbit());
    drive(1, rbit(), rbit());
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("reset_a c=%0d", c), get_obs(0), model(0, NR, 1));
      check($sformatf("reset_b c=%0d", c), get_obs(1), model(0, NR, 3));
      drive(0, rbit(), rbit());
      drive(1, rbit(), rbit());
    end
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    tick();
    check("idle_a", get_obs(0), model(0, NR, 1));

    run_seq(0, 1, 0, 1'b0, 0, 1'b0, "nominal");
    run_seq(0, 1, 5, 1'b1, 0, 1'b0, "backpressure");
    run_seq(0, 6, 0, 1'b0, 0, 1'b0, "start_busy");
    run_seq(0, 1, 0, 1'b0, 7, 1'b0, "reset_mid");
    run_seq(0, 1, 0, 1'b0, 0, 1'b0, "after_reset");
    run_seq(1, 1, 0, 1'b0, 0, 1'b0, "rc3");
    run_seq(1, 4, 3, 1'b1, 0, 1'b1, "rc3_bp");

    // Randomized requests: start holding, backpressure, noise and mid-op resets
    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 1));
      rc  = (sel == 0) ? 1 : 3;
      run_seq(sel, int'($urandom_range(1, 8)), int'($urandom_range(0, 6)), rbit(),
              (($urandom_range(0, 2)) == 0) ? int'($urandom_range(2, NR * rc + 1)) : 0,
              1'b1, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
